mac_seq_ctrl: RTL and testbench

//  Sequencer for the combinational mac_4 datapath (out = a*b + c, DATA_WIDTH bits).

---
 rtl/mac_seq_ctrl.sv | 155 +++++++++++++++
 tb/tb_mac_seq_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mac_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mac_seq_ctrl
//
// Purpose:
//   Sequencer for an external combinational MAC (out = a*b + c). A job is
//   started with an initial accumulator value. VEC_LEN operand pairs are then
//   streamed through the MAC, and each MAC result is fed back as the next c.
//   The final dot-product is presented on a valid/ready output port.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start, init_c     job start pulse (IDLE only) and initial accumulator
//   in_valid/in_ready operand pair handshake, operands in_a / in_b
//   mac_a/b/c         drive the external MAC (a, b, current accumulator)
//   mac_out           combinational MAC result, same cycle
//   out_valid/ready   result handshake, result on out_res
//   busy              high while a job is in RUN or DONE
//   mac_err           sticky MAC mismatch flag
//
// Build option:
//   MAC_CHECK_EN  When this macro is defined, a shadow MAC recomputes every
//                 accepted beat. Any difference from mac_out sets mac_err.
//                 mac_err stays set until rst. When the macro is undefined,
//                 mac_err is tied to 0.
// ---------------------------------------------------------------------------
module mac_seq_ctrl #(
   parameter int DATA_WIDTH = 4,
   parameter int VEC_LEN    = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] init_c,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_a,
   input  logic [DATA_WIDTH-1:0] in_b,
   output logic [DATA_WIDTH-1:0] mac_a,
   output logic [DATA_WIDTH-1:0] mac_b,
   output logic [DATA_WIDTH-1:0] mac_c,
   input  logic [DATA_WIDTH-1:0] mac_out,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_res,
   output logic                  busy,
   output logic                  mac_err
);

   localparam int CNT_W = $clog2(VEC_LEN + 1);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(VEC_LEN - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                state_reg, state_next;
   logic [DATA_WIDTH-1:0] acc_reg,   acc_next;
   logic [CNT_W-1:0]      cnt_reg,   cnt_next;
   logic [DATA_WIDTH-1:0] res_reg,   res_next;
   logic                  beat;

   // In RUN, in_ready is always high. A beat is therefore any valid operand
   // pair that arrives while the controller is in RUN.
   assign beat = (state_reg == RUN) && in_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         acc_reg   <= '0;
         cnt_reg   <= '0;
         res_reg   <= '0;
      end else begin
         state_reg <= state_next;
         acc_reg   <= acc_next;
         cnt_reg   <= cnt_next;
         res_reg   <= res_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      acc_next   = acc_reg;
      cnt_next   = cnt_reg;
      res_next   = res_reg;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      mac_a      = '0;
      mac_b      = '0;
      // The accumulator always drives c. The accumulator is cleared by
      // reset, so this output is 0 right after reset.
      mac_c      = acc_reg;

      case (state_reg)
         IDLE: begin
            if (start) begin
               acc_next   = init_c;
               cnt_next   = '0;
               state_next = RUN;
            end
         end
         RUN: begin
            in_ready = 1'b1;
            mac_a    = in_a;
            mac_b    = in_b;
            if (beat) begin
               acc_next = mac_out;
               cnt_next = cnt_reg + 1'b1;
               if (cnt_reg == LAST_BEAT) begin
                  res_next   = mac_out;
                  state_next = DONE;
               end
            end
         end
         DONE: begin
            // A start pulse in this state is dropped on purpose. This also
            // applies in the handshake cycle. A new job needs a start pulse
            // after the controller has returned to IDLE.
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign busy    = (state_reg != IDLE);
   assign out_res = res_reg;

`ifdef MAC_CHECK_EN
   logic [DATA_WIDTH-1:0] shadow_res;
   logic                  err_reg;

   // All operands are DATA_WIDTH bits wide, so the sum wraps modulo 2^W,
   // exactly as the external MAC does.
   assign shadow_res = in_a * in_b + acc_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         err_reg <= 1'b0;
      end else if (beat && (shadow_res != mac_out)) begin
         err_reg <= 1'b1;
      end
   end

   assign mac_err = err_reg;
`else
   assign mac_err = 1'b0;
`endif

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mac_seq_ctrl
//
// Self-checking bench for mac_seq_ctrl. A behavioural MAC is attached to the
// DUT. This MAC can add 1 to its result on a selected beat, which emulates a
// faulty fabric MAC. The expected result of each job is pushed to a queue
// after the job's last beat is driven. It is popped and compared at the
// output handshake.
// ---------------------------------------------------------------------------
module tb_mac_seq_ctrl;

   localparam int DW = 4;
   localparam int VL = 4;
   localparam int MASK = (1 << DW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [DW-1:0] init_c = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_a = '0;
   logic [DW-1:0] in_b = '0;
   logic [DW-1:0] mac_a, mac_b, mac_c, mac_out;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_res;
   logic          busy;
   logic          mac_err;
   logic [DW-1:0] fault_add = '0;

   int checks = 0;
   int errors = 0;
   int va[VL];
   int vb[VL];
   int sb_q[$];
   int err_exp = 0;
   int job_id = 0;

   always #5 clk = ~clk;

   // Golden MAC, with optional fault injection.
   assign mac_out = mac_a * mac_b + mac_c + fault_add;

   mac_seq_ctrl #(.DATA_WIDTH(DW), .VEC_LEN(VL)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .init_c    (init_c),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .mac_a     (mac_a),
      .mac_b     (mac_b),
      .mac_c     (mac_c),
      .mac_out   (mac_out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_res   (out_res),
      .busy      (busy),
      .mac_err   (mac_err)
   );

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Runs one job using the va/vb operands.
   //   gap         idle cycles before each beat; start is pulsed during them
   //   hold        cycles with out_ready low before the handshake
   //   fault_beat  beat on which the MAC adds 1 (-1 for none)
   //   abort_after number of beats accepted before rst is applied (-1 for none)
   task automatic run_job(input int init, input int gap, input int hold,
                          input int fault_beat, input int abort_after);
      int acc_m;
      int n;
      int exp;
      job_id++;
      acc_m  = init & MASK;
      init_c = DW'(init);
      start  = 1'b1;
      step();
      start  = 1'b0;
      chk("busy_run", busy, 1);
      chk("in_ready_run", in_ready, 1);
      for (int i = 0; i < VL; i++) begin
         if (abort_after == i) begin
            rst = 1'b1;
            step();
            rst = 1'b0;
            err_exp = 0;
            chk("abort_busy", busy, 0);
            chk("abort_in_ready", in_ready, 0);
            chk("abort_out_valid", out_valid, 0);
            chk("abort_acc", mac_c, 0);
            $display("job %0d aborted by rst after %0d beats", job_id, i);
            return;
         end
         for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            start    = 1'b1;
            step();
            start    = 1'b0;
            chk("gap_in_ready", in_ready, 1);
            chk("gap_busy", busy, 1);
         end
         in_valid  = 1'b1;
         in_a      = DW'(va[i]);
         in_b      = DW'(vb[i]);
         fault_add = (i == fault_beat) ? DW'(1) : DW'(0);
         #1;
         chk("mac_a", mac_a, va[i] & MASK);
         chk("mac_c", mac_c, acc_m);
         acc_m = (va[i] * vb[i] + acc_m + ((i == fault_beat) ? 1 : 0)) & MASK;
`ifdef MAC_CHECK_EN
         if (i == fault_beat) err_exp = 1;
`endif
         step();
         in_valid  = 1'b0;
         fault_add = '0;
      end
      sb_q.push_back(acc_m);
      chk("out_valid_lat", out_valid, 1);
      chk("done_in_ready", in_ready, 0);
      for (int h = 0; h < hold; h++) begin
         out_ready = 1'b0;
         start     = 1'b1;
         step();
         start     = 1'b0;
         chk("hold_valid", out_valid, 1);
         chk("hold_res", out_res, sb_q[0]);
         chk("hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      n = 0;
      while (!out_valid && n < 50) begin
         step();
         n++;
      end
      if (n == 50) begin
         chk("out_timeout", 0, 1);
         out_ready = 1'b0;
         return;
      end
      exp = sb_q.pop_front();
      chk("out_res", out_res, exp);
      start = 1'b1;
      step();
      out_ready = 1'b0;
      start     = 1'b0;
      chk("post_valid", out_valid, 0);
      chk("post_busy", busy, 0);
      chk("post_res_kept", out_res, exp);
      chk("mac_err", mac_err, err_exp);
      step();
      chk("start_at_hs_ignored", busy, 0);
      $display("job %0d init=%0d result=%0d expected=%0d", job_id, init, out_res, exp);
   endtask

   initial begin
      rst  = 1'b1;
      in_a = 4'd7;
      in_b = 4'd9;
      repeat (3) step();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_mac_a", mac_a, 0);
      chk("rst_mac_b", mac_b, 0);
      chk("rst_mac_c", mac_c, 0);
      chk("rst_out_res", out_res, 0);
      chk("rst_mac_err", mac_err, 0);
      rst = 1'b0;
      step();

      // Dot product 3 + 6 + 1 + 16 + 0 = 26, which is 10 mod 16.
      va = '{2, 1, 4, 0};
      vb = '{3, 1, 4, 7};
      run_job(3, 0, 0, -1, -1);
      run_job(3, 2, 5, -1, -1);

      // Wrap: 15 + 4*225 = 915, which is 3 mod 16.
      va = '{15, 15, 15, 15};
      vb = '{15, 15, 15, 15};
      run_job(15, 0, 1, -1, -1);

      // Abort after the 2nd beat, then run a clean job.
      va = '{1, 1, 1, 1};
      vb = '{1, 1, 1, 1};
      run_job(5, 0, 0, -1, 2);
      run_job(0, 0, 0, -1, -1);

      // rst and start in the same cycle: rst wins.
      rst   = 1'b1;
      start = 1'b1;
      step();
      rst   = 1'b0;
      start = 1'b0;
      step();
      chk("rst_start_busy", busy, 0);

      // Faulty MAC on beat 2. The flag must stay set through the next job.
      va = '{2, 3, 1, 5};
      vb = '{1, 2, 6, 3};
      run_job(4, 0, 0, 1, -1);
      run_job(1, 1, 0, -1, -1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      err_exp = 0;
      chk("err_cleared", mac_err, 0);
      step();

      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < VL; k++) begin
            va[k] = int'($urandom_range(0, MASK));
            vb[k] = int'($urandom_range(0, MASK));
         end
         run_job(int'($urandom_range(0, MASK)), r % 2, r, -1, -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
